// File: rtl/i2c_pt_pkg.sv
// Shared types and constants for the I2C passthrough direction controller.
package i2c_pt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_A,
        WDATA,
        ACK_W,
        RDATA,
        ACK_R,
        WAIT_P
    } state_e;

    localparam logic DIR_M2T = 1'b0;
    localparam logic DIR_T2M = 1'b1;

    localparam int unsigned BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_in_filter.sv
// Pad input conditioning: 2-FF synchronizer followed by a stable-count glitch filter.
// Filtered output idles high so a released open-drain line reads as 1 after reset.
module i2c_in_filter #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad_i,
    output logic filt_o
);

    logic [1:0] sync_q;
    logic       filt_q;
    logic [3:0] cnt_q;

    // A new level is accepted only after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], pad_i};
            if (sync_q[1] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == 4'(FILT_LEN - 1)) begin
                filt_q <= sync_q[1];
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/i2c_sda_dir_ctrl.sv
// SDA direction controller for the bidirectional I2C passthrough.
// Optional target clock stretching forwarded to the controller under `STRETCH_EN.
module i2c_sda_dir_ctrl
    import i2c_pt_pkg::*;
#(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_m_in,
    input  logic sda_m_in,
    input  logic sda_t_in,
    input  logic scl_t_in,
    output logic sda_m_oe,
    output logic sda_t_oe,
    output logic scl_t_oe,
    output logic scl_m_oe,
    output logic dir,
    output logic busy
);

    localparam logic [3:0] BYTE_BITS = 4'(BITS_PER_BYTE);
    localparam logic [3:0] LAST_BIT  = 4'(BITS_PER_BYTE - 1);

    logic   scl_m_f, sda_m_f, sda_t_f;
    logic   scl_prev_q, sda_prev_q;
    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic   dir_q, dir_d;
    logic   busy_q, busy_d;
    logic   rw_q, rw_d;
    logic   ack_q, ack_d;
    logic   sda_m_oe_q, sda_t_oe_q, scl_t_oe_q;
    logic   edge_ok, scl_fwd_lo;
    logic   scl_rise, scl_fall, scl_hold_hi, start_c, stop_c;

    i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_scl_m (
        .clk(clk), .rst_n(rst_n), .pad_i(scl_m_in), .filt_o(scl_m_f));
    i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_sda_m (
        .clk(clk), .rst_n(rst_n), .pad_i(sda_m_in), .filt_o(sda_m_f));
    i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_sda_t (
        .clk(clk), .rst_n(rst_n), .pad_i(sda_t_in), .filt_o(sda_t_f));

`ifdef STRETCH_EN
    localparam logic [4:0] HOLDOFF = 5'(FILT_LEN + 3);

    logic       scl_t_f;
    logic [4:0] hold_q;
    logic       stretch_q, blk_q;

    i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_scl_t (
        .clk(clk), .rst_n(rst_n), .pad_i(scl_t_in), .filt_o(scl_t_f));

    // Holdoff hides the echo of our own pull-down; blk masks the SCL dip we cause.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q    <= '0;
            stretch_q <= 1'b0;
            blk_q     <= 1'b0;
        end else begin
            hold_q    <= scl_t_oe_q ? '0 : ((hold_q == HOLDOFF) ? hold_q : hold_q + 5'd1);
            stretch_q <= stretch_q ? !scl_t_f
                                   : (!scl_t_oe_q && (hold_q == HOLDOFF) && !scl_t_f);
            blk_q     <= stretch_q || (blk_q && !scl_m_f);
        end
    end

    assign scl_m_oe   = stretch_q;
    assign edge_ok    = !stretch_q && !blk_q;
    assign scl_fwd_lo = !scl_m_f && !stretch_q && !blk_q;
`else
    logic unused_scl_t;
    assign unused_scl_t = scl_t_in;
    assign scl_m_oe     = 1'b0;
    assign edge_ok      = 1'b1;
    assign scl_fwd_lo   = !scl_m_f;
`endif

    assign scl_rise    = edge_ok && scl_m_f && !scl_prev_q;
    assign scl_fall    = edge_ok && !scl_m_f && scl_prev_q;
    // Any SCL movement this cycle suppresses START/STOP decoding.
    assign scl_hold_hi = scl_m_f && scl_prev_q;
    assign start_c     = scl_hold_hi && sda_prev_q && !sda_m_f && (dir_q == DIR_M2T);
    assign stop_c      = scl_hold_hi && !sda_prev_q && sda_m_f && (dir_q == DIR_M2T);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        busy_d  = busy_q;
        rw_d    = rw_q;
        ack_d   = ack_q;
        if (stop_c) begin
            state_d = IDLE;
            cnt_d   = '0;
            dir_d   = DIR_M2T;
            busy_d  = 1'b0;
        end else if (start_c) begin
            state_d = ADDR;
            cnt_d   = '0;
            dir_d   = DIR_M2T;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                ADDR, WDATA, RDATA: begin
                    if (scl_rise && cnt_q != BYTE_BITS) begin
                        cnt_d = cnt_q + 4'd1;
                        if (state_q == ADDR && cnt_q == LAST_BIT) rw_d = sda_m_f;
                    end
                    if (scl_fall && cnt_q == BYTE_BITS) begin
                        case (state_q)
                            ADDR:    begin state_d = ACK_A; dir_d = DIR_T2M; end
                            WDATA:   begin state_d = ACK_W; dir_d = DIR_T2M; end
                            default: begin state_d = ACK_R; dir_d = DIR_M2T; end
                        endcase
                    end
                end
                ACK_A, ACK_W, ACK_R: begin
                    if (scl_rise) ack_d = (state_q == ACK_R) ? !sda_m_f : !sda_t_f;
                    if (scl_fall) begin
                        cnt_d = '0;
                        if (!ack_q) begin
                            state_d = WAIT_P;
                            dir_d   = DIR_M2T;
                        end else if (state_q == ACK_W || (state_q == ACK_A && !rw_q)) begin
                            state_d = WDATA;
                            dir_d   = DIR_M2T;
                        end else begin
                            state_d = RDATA;
                            dir_d   = DIR_T2M;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dir_q      <= DIR_M2T;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            ack_q      <= 1'b0;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            sda_m_oe_q <= 1'b0;
            sda_t_oe_q <= 1'b0;
            scl_t_oe_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
            scl_prev_q <= scl_m_f;
            sda_prev_q <= sda_m_f;
            sda_t_oe_q <= (dir_q == DIR_M2T) && !sda_m_f;
            sda_m_oe_q <= (dir_q == DIR_T2M) && !sda_t_f;
            scl_t_oe_q <= scl_fwd_lo;
        end
    end

    assign sda_m_oe = sda_m_oe_q;
    assign sda_t_oe = sda_t_oe_q;
    assign scl_t_oe = scl_t_oe_q;
    assign dir      = dir_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_sda_dir_ctrl.sv
// Bench for i2c_sda_dir_ctrl: wired-AND pad buses on both sides, byte-level ownership model.
module tb_i2c_sda_dir_ctrl;

    localparam int unsigned FILT_LEN = 3;
    localparam int Q = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ctl_scl = 1'b1;
    logic ctl_sda = 1'b1;
    logic tgt_sda = 1'b1;
    logic sda_m_oe, sda_t_oe, scl_t_oe, scl_m_oe, dir, busy;
    logic m_sda, t_sda, m_scl, t_scl;

    int checks = 0;
    int failures = 0;

    assign m_sda = ctl_sda & ~sda_m_oe;
    assign t_sda = tgt_sda & ~sda_t_oe;
    assign m_scl = ctl_scl & ~scl_m_oe;
    assign t_scl = ~scl_t_oe;

    always #5 clk = ~clk;

    i2c_sda_dir_ctrl #(.FILT_LEN(FILT_LEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .scl_m_in(m_scl), .sda_m_in(m_sda), .sda_t_in(t_sda), .scl_t_in(t_scl),
        .sda_m_oe(sda_m_oe), .sda_t_oe(sda_t_oe), .scl_t_oe(scl_t_oe), .scl_m_oe(scl_m_oe),
        .dir(dir), .busy(busy));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period; whoever owns the slot drives it, the other side must see it.
    task automatic bit_slot(input logic val, input bit tgt_owns, input string tag, output logic seen);
        wait_clks(Q);
        ctl_sda = tgt_owns ? 1'b1 : val;
        tgt_sda = tgt_owns ? val : 1'b1;
        wait_clks(Q);
        ctl_scl = 1'b1;
        wait_clks(Q);
        check_eq({tag, ".dir"}, 32'(dir), 32'(tgt_owns));
        check_eq({tag, ".busy"}, 32'(busy), 32'd1);
        seen = tgt_owns ? m_sda : t_sda;
        check_eq({tag, ".bit"}, 32'(seen), 32'(val));
        wait_clks(Q);
        ctl_scl = 1'b0;
    endtask

    // rd=1: target sends the 8 data bits and the controller acknowledges.
    task automatic do_byte(input logic [7:0] data, input bit rd, input bit ack, input string tag);
        logic [7:0] got;
        logic s;
        got = '0;
        for (int i = 0; i < 8; i++) begin
            bit_slot(data[7-i], rd, $sformatf("%s.b%0d", tag, i), s);
            got = {got[6:0], s};
        end
        bit_slot(~ack, ~rd, {tag, ".ack"}, s);
        check_eq({tag, ".byte"}, 32'(got), 32'(data));
    endtask

    task automatic start_cond(input string tag);
        ctl_scl = 1'b1; ctl_sda = 1'b1; tgt_sda = 1'b1;
        wait_clks(2 * Q);
        check_eq({tag, ".idle_busy"}, 32'(busy), 32'd0);
        ctl_sda = 1'b0;
        wait_clks(Q);
        check_eq({tag, ".start_busy"}, 32'(busy), 32'd1);
        check_eq({tag, ".start_fwd"}, 32'(t_sda), 32'd0);
        ctl_scl = 1'b0;
        wait_clks(5);
        check_eq({tag, ".scl_lat5"}, 32'(scl_t_oe), 32'd0);
        wait_clks(1);
        check_eq({tag, ".scl_lat6"}, 32'(scl_t_oe), 32'd1);
    endtask

    task automatic rep_start(input string tag);
        wait_clks(Q);
        ctl_sda = 1'b1; tgt_sda = 1'b1;
        wait_clks(Q);
        ctl_scl = 1'b1;
        wait_clks(Q);
        check_eq({tag, ".rs_dir"}, 32'(dir), 32'd0);
        ctl_sda = 1'b0;
        wait_clks(Q);
        check_eq({tag, ".rs_busy"}, 32'(busy), 32'd1);
        ctl_scl = 1'b0;
    endtask

    task automatic stop_cond(input string tag);
        wait_clks(Q);
        ctl_sda = 1'b0; tgt_sda = 1'b1;
        wait_clks(Q);
        ctl_scl = 1'b1;
        wait_clks(Q);
        check_eq({tag, ".pre_stop_busy"}, 32'(busy), 32'd1);
        ctl_sda = 1'b1;
        wait_clks(5);
        check_eq({tag, ".stop_lat5"}, 32'(busy), 32'd1);
        wait_clks(1);
        check_eq({tag, ".stop_lat6"}, 32'(busy), 32'd0);
        check_eq({tag, ".stop_dir"}, 32'(dir), 32'd0);
        wait_clks(Q);
        check_eq({tag, ".idle_oe"}, {29'd0, sda_m_oe, sda_t_oe, scl_t_oe}, 32'd0);
    endtask

    task automatic glitch(input int n, input bit expect_det, input string tag);
        logic seen_busy;
        seen_busy = 1'b0;
        ctl_sda = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == n) ctl_sda = 1'b1;
            wait_clks(1);
            if (busy === 1'b1) seen_busy = 1'b1;
        end
        check_eq({tag, ".detected"}, 32'(seen_busy), 32'(expect_det));
        check_eq({tag, ".end_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic random_xfer(input int k);
        logic [7:0] abyte, d;
        bit aack, ack;
        int n;
        string tag;
        tag = $sformatf("rnd%0d", k);
        abyte = 8'($urandom);
        aack = ($urandom_range(0, 3) != 0);
        start_cond(tag);
        do_byte(abyte, 1'b0, aack, {tag, ".addr"});
        if (aack) begin
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) begin
                d = 8'($urandom);
                if (abyte[0]) begin
                    ack = (j != n - 1);
                    do_byte(d, 1'b1, ack, $sformatf("%s.rd%0d", tag, j));
                end else begin
                    ack = ($urandom_range(0, 3) != 0);
                    do_byte(d, 1'b0, ack, $sformatf("%s.wr%0d", tag, j));
                    if (!ack) break;
                end
            end
        end
        stop_cond(tag);
    endtask

    initial begin
        logic s;
        wait_clks(4);
        check_eq("reset.oe", {28'd0, sda_m_oe, sda_t_oe, scl_t_oe, scl_m_oe}, 32'd0);
        check_eq("reset.dir", 32'(dir), 32'd0);
        check_eq("reset.busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        wait_clks(2 * Q);

        start_cond("w1");
        do_byte(8'h50, 1'b0, 1'b1, "w1.addr");
        do_byte(8'hA5, 1'b0, 1'b1, "w1.d0");
        stop_cond("w1");

        start_cond("r1");
        do_byte(8'h51, 1'b0, 1'b1, "r1.addr");
        do_byte(8'h3C, 1'b1, 1'b0, "r1.d0");
        stop_cond("r1");

        start_cond("n1");
        do_byte(8'h22, 1'b0, 1'b0, "n1.addr");
        for (int i = 0; i < 9; i++) bit_slot(1'($urandom), 1'b0, $sformatf("n1.wait%0d", i), s);
        rep_start("n1");
        do_byte(8'h50, 1'b0, 1'b1, "n1.addr2");
        do_byte(8'($urandom), 1'b0, 1'b1, "n1.d0");
        stop_cond("n1");

        start_cond("rs");
        do_byte(8'h50, 1'b0, 1'b1, "rs.addr");
        do_byte(8'h96, 1'b0, 1'b1, "rs.d0");
        rep_start("rs");
        do_byte(8'h51, 1'b0, 1'b1, "rs.addr2");
        do_byte(8'h5A, 1'b1, 1'b1, "rs.rd0");
        do_byte(8'hC3, 1'b1, 1'b0, "rs.rd1");
        stop_cond("rs");

        wait_clks(2 * Q);
        glitch(int'(FILT_LEN) - 1, 1'b0, "glitch_short");
        glitch(int'(FILT_LEN) + 1, 1'b1, "glitch_long");

        start_cond("rst");
        do_byte(8'h51, 1'b0, 1'b1, "rst.addr");
        for (int i = 0; i < 4; i++) bit_slot(1'($urandom), 1'b1, $sformatf("rst.b%0d", i), s);
        wait_clks(Q);
        tgt_sda = 1'b0;
        wait_clks(Q);
        check_eq("rst.pre_dir", 32'(dir), 32'd1);
        check_eq("rst.pre_oe", {30'd0, sda_m_oe, scl_t_oe}, 32'd3);
        rst_n = 1'b0;
        wait_clks(1);
        check_eq("rst.oe", {28'd0, sda_m_oe, sda_t_oe, scl_t_oe, scl_m_oe}, 32'd0);
        check_eq("rst.dir", 32'(dir), 32'd0);
        check_eq("rst.busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tgt_sda = 1'b1;
        ctl_scl = 1'b1;
        ctl_sda = 1'b1;
        wait_clks(4 * Q);
        check_eq("rst.after_busy", 32'(busy), 32'd0);
        start_cond("post");
        do_byte(8'h50, 1'b0, 1'b1, "post.addr");
        do_byte(8'h0F, 1'b0, 1'b1, "post.d0");
        stop_cond("post");

        for (int k = 0; k < 8; k++) random_xfer(k);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        repeat (150000) @(posedge clk);
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
